hazard_stage_tracker: RTL

- Producer side of the decode-stage hazard/forwarding comparator. Its outputs are the comparator's inputs: destination register, bubble flag and write-enable for each of EX, MEM and WB.
- Consumer side of the comparator's stall request. Holds IF/ID, injects a bubble into ID/EX, and applies branch flushes and global memory holds.
- Keeps a saturating stall-cycle counter and a stuck-stall watchdog.

---
 rtl/hazard_stage_tracker_if.sv | 44 ++++
 rtl/hazard_stage_tracker.sv | 124 ++++++++++++
 2 files changed

// File: rtl/hazard_stage_tracker_if.sv
// Bundle between the decode-stage hazard comparator and the stage tracker.
// master = comparator/decode side, slave = tracker side.
interface hazard_stage_tracker_if #(
   parameter int unsigned CNT_W = 16
);
   // Decode-stage instruction and control requests
   logic [2:0]       id_dst;
   logic             id_regwrt;
   logic [1:0]       id_regsrc;
   logic             id_valid;
   logic             sendNOP;
   logic             flush;
   logic             mem_hold;
   // Registered stage view fed back to the comparator
   logic [2:0]       execute;
   logic [2:0]       memory;
   logic [2:0]       writeback;
   logic             NOPEx;
   logic             NOPMem;
   logic             NOPWB;
   logic             RegWrt_out_ID_EX;
   logic [1:0]       RegSrc_out_ID_EX;
   logic             WRMEM;
   logic             WRWB;
   // Front-end control and diagnostics
   logic             if_id_hold;
   logic             id_squash;
   logic [CNT_W-1:0] stall_cnt;
   logic             stall_err;

   modport master (
      output id_dst, id_regwrt, id_regsrc, id_valid, sendNOP, flush, mem_hold,
      input  execute, memory, writeback, NOPEx, NOPMem, NOPWB,
      input  RegWrt_out_ID_EX, RegSrc_out_ID_EX, WRMEM, WRWB,
      input  if_id_hold, id_squash, stall_cnt, stall_err
   );

   modport slave (
      input  id_dst, id_regwrt, id_regsrc, id_valid, sendNOP, flush, mem_hold,
      output execute, memory, writeback, NOPEx, NOPMem, NOPWB,
      output RegWrt_out_ID_EX, RegSrc_out_ID_EX, WRMEM, WRWB,
      output if_id_hold, id_squash, stall_cnt, stall_err
   );
endinterface

// File: rtl/hazard_stage_tracker.sv
// EX/MEM/WB destination tracker for the decode-stage hazard comparator.
// Applies stall bubbles, branch flushes and memory holds, counts stall
// cycles and flags a stall that lasts MAX_STALL consecutive cycles.
module hazard_stage_tracker #(
   parameter int unsigned CNT_W     = 16,
   parameter int unsigned MAX_STALL = 4
) (
   input logic                  clk,
   input logic                  rst,
   hazard_stage_tracker_if.slave bus
);

   typedef struct packed {
      logic       valid;
      logic [2:0] dst;
      logic       regwrt;
      logic [1:0] regsrc;
   } stage_t;

   typedef enum logic [1:0] {ActHold, ActFlush, ActStall, ActRun} action_t;

   localparam stage_t     Bubble = '0;
   localparam logic [3:0] MaxRun = 4'(MAX_STALL);

   action_t          action;
   stage_t           ex_q, mem_q, wb_q;
   stage_t           ex_d, mem_d, wb_d;
   stage_t           id_entry;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       run_q, run_d;
   logic             err_q, err_d;

   // Resolve this cycle's action by priority and drive the front-end controls
   always_comb begin
      action          = ActRun;
      bus.if_id_hold  = 1'b0;
      bus.id_squash   = 1'b0;
      if (bus.mem_hold) begin
         action         = ActHold;
         bus.if_id_hold = 1'b1;
      end else if (bus.flush) begin
         action         = ActFlush;
         bus.id_squash  = 1'b1;
      end else if (!bus.sendNOP) begin
         action         = ActStall;
         bus.if_id_hold = 1'b1;
      end
   end

   // Next-state for the stage registers and the stall counters
   always_comb begin
      id_entry.valid  = bus.id_valid;
      id_entry.dst    = bus.id_dst;
      id_entry.regwrt = bus.id_regwrt & bus.id_valid;
      id_entry.regsrc = bus.id_valid ? bus.id_regsrc : 2'b00;

      ex_d  = ex_q;
      mem_d = mem_q;
      wb_d  = wb_q;
      cnt_d = cnt_q;
      run_d = run_q;

      unique case (action)
         ActHold: ;
         ActFlush: begin
            ex_d  = Bubble;
            mem_d = ex_q;
            wb_d  = mem_q;
            run_d = '0;
         end
         ActStall: begin
            ex_d  = Bubble;
            mem_d = ex_q;
            wb_d  = mem_q;
            cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
            run_d = (run_q == 4'hF) ? run_q : run_q + 4'd1;
         end
         ActRun: begin
            ex_d  = id_entry;
            mem_d = ex_q;
            wb_d  = mem_q;
            run_d = '0;
         end
         default: ;
      endcase

      // Sticky once the consecutive-stall run reaches the limit
      err_d = err_q | (run_d >= MaxRun);
   end

   // State registers with asynchronous reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_q  <= Bubble;
         mem_q <= Bubble;
         wb_q  <= Bubble;
         cnt_q <= '0;
         run_q <= '0;
         err_q <= 1'b0;
      end else begin
         ex_q  <= ex_d;
         mem_q <= mem_d;
         wb_q  <= wb_d;
         cnt_q <= cnt_d;
         run_q <= run_d;
         err_q <= err_d;
      end
   end

   // Outputs are taken directly from registers so the comparator loop stays broken
   assign bus.execute          = ex_q.dst;
   assign bus.memory           = mem_q.dst;
   assign bus.writeback        = wb_q.dst;
   assign bus.NOPEx            = ex_q.valid;
   assign bus.NOPMem           = mem_q.valid;
   assign bus.NOPWB            = wb_q.valid;
   assign bus.RegWrt_out_ID_EX = ex_q.regwrt & ex_q.valid;
   assign bus.RegSrc_out_ID_EX = ex_q.valid ? ex_q.regsrc : 2'b00;
   assign bus.WRMEM            = mem_q.regwrt & mem_q.valid;
   assign bus.WRWB             = wb_q.regwrt & wb_q.valid;
   assign bus.stall_cnt        = cnt_q;
   assign bus.stall_err        = err_q;

endmodule
